// File: rtl/wr_arb_pkg.sv
// Types and defaults shared by the write arbiter core and the grant controller.
package wr_arb_pkg;

  localparam int unsigned DEF_NUM_PORTS = 16;
  localparam int unsigned DEF_SEL_W     = 4;
  localparam int unsigned DEF_DATA_W    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDrain
  } wr_state_e;

  // LSB position of port idx's beat in a packed per-port data bus.
  function automatic int unsigned beat_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/port_beat_mux.sv
// Combinational NUM_PORTS:1 selection of beat data/valid/eop by grant index.
module port_beat_mux
  import wr_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_PORTS*DATA_W-1:0] port_data,
  input  logic [NUM_PORTS-1:0]        port_valid,
  input  logic [NUM_PORTS-1:0]        port_eop,
  output logic [DATA_W-1:0]           data,
  output logic                        valid,
  output logic                        eop
);

  assign data  = port_data[beat_lo(int'(sel), DATA_W) +: DATA_W];
  assign valid = port_valid[sel];
  assign eop   = port_eop[sel];

endmodule

// File: rtl/write_grant_ctrl.sv
// Locks the arbiter's chosen port, forwards its packet to the SRAM write path and acks the
// arbiter once per packet; aborts stalled (idle timeout) or oversized packets.
module write_grant_ctrl
  import wr_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_valid,
  input  logic [SEL_W-1:0]            arb_select,
  output logic                        arb_ack,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS*DATA_W-1:0] port_data,
  input  logic [NUM_PORTS-1:0]        port_valid,
  input  logic [NUM_PORTS-1:0]        port_eop,
  output logic [NUM_PORTS-1:0]        port_ready,
  input  logic                        wr_ready,
  output logic                        wr_valid,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        wr_sop,
  output logic                        wr_eop,
  output logic [SEL_W-1:0]            wr_port,
  output logic                        busy,
  output logic                        err_abort
);

  localparam int unsigned CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  wr_state_e         state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              err_abort_q, err_abort_d;

  logic [DATA_W-1:0]    sel_data;
  logic                 sel_valid;
  logic                 sel_eop;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic                 last_len;
  logic                 idle_hit;

  port_beat_mux #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W),
    .DATA_W    (DATA_W)
  ) u_mux (
    .sel        (grant_q),
    .port_data  (port_data),
    .port_valid (port_valid),
    .port_eop   (port_eop),
    .data       (sel_data),
    .valid      (sel_valid),
    .eop        (sel_eop)
  );

  assign grant_onehot = NUM_PORTS'(1) << grant_q;
  assign last_len     = (beat_cnt_q == CNT_W'(MAX_WORDS - 1));
  // Fires on the TIMEOUT-th consecutive cycle without a valid beat.
  assign idle_hit     = !sel_valid && (idle_cnt_q == IDLE_W'(TIMEOUT - 1));
  assign err_abort    = err_abort_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    err_abort_d = 1'b0;
    arb_ack     = 1'b0;
    port_ready  = '0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    wr_sop      = 1'b0;
    wr_eop      = 1'b0;
    wr_port     = '0;
    busy        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid && port_req[arb_select] && !rst) begin
          arb_ack    = 1'b1;
          grant_d    = arb_select;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = StXfer;
        end
      end

      StXfer: begin
        busy       = 1'b1;
        wr_port    = grant_q;
        wr_valid   = sel_valid;
        wr_data    = sel_data;
        port_ready = grant_onehot & {NUM_PORTS{wr_ready}};
        wr_sop     = sel_valid && (beat_cnt_q == '0);
        wr_eop     = sel_valid && (sel_eop || last_len);
        if (sel_valid && wr_ready) begin
          idle_cnt_d = '0;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (sel_eop) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
          end else if (last_len) begin
            err_abort_d = 1'b1;
            state_d     = StDrain;
          end
        end else if (sel_valid) begin
          // Backpressure is not idleness.
          idle_cnt_d = '0;
        end else if (idle_hit) begin
          err_abort_d = 1'b1;
          state_d     = StIdle;
          beat_cnt_d  = '0;
          idle_cnt_d  = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      StDrain: begin
        busy       = 1'b1;
        wr_port    = grant_q;
        port_ready = grant_onehot;
        if (sel_valid) begin
          idle_cnt_d = '0;
          if (sel_eop) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
          end
        end else if (idle_hit) begin
          err_abort_d = 1'b1;
          state_d     = StIdle;
          beat_cnt_d  = '0;
          idle_cnt_d  = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      err_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      err_abort_q <= err_abort_d;
    end
  end

endmodule

// File: tb/tb_write_grant_ctrl.sv
// Directed bench for write_grant_ctrl: grant, backpressure, length abort, timeout, reset.
module tb_write_grant_ctrl;

  localparam int unsigned NP = 16;
  localparam int unsigned DW = 32;
  localparam logic [NP-1:0] NOISE_V = 16'h5A5A;
  localparam logic [NP-1:0] NOISE_E = 16'h0F0F;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_valid;
  logic [3:0]      arb_select;
  logic            arb_ack;
  logic [NP-1:0]   port_req;
  logic [NP*DW-1:0] port_data;
  logic [NP-1:0]   port_valid;
  logic [NP-1:0]   port_eop;
  logic [NP-1:0]   port_ready;
  logic            wr_ready;
  logic            wr_valid;
  logic [DW-1:0]   wr_data;
  logic            wr_sop;
  logic            wr_eop;
  logic [3:0]      wr_port;
  logic            busy;
  logic            err_abort;

  int n_tests = 0;
  int n_fail  = 0;

  write_grant_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .arb_valid  (arb_valid),
    .arb_select (arb_select),
    .arb_ack    (arb_ack),
    .port_req   (port_req),
    .port_data  (port_data),
    .port_valid (port_valid),
    .port_eop   (port_eop),
    .port_ready (port_ready),
    .wr_ready   (wr_ready),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_sop     (wr_sop),
    .wr_eop     (wr_eop),
    .wr_port    (wr_port),
    .busy       (busy),
    .err_abort  (err_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int p, input int k);
    return {8'hA5, 8'(p), 16'(k)};
  endfunction

  task automatic set_beat(input int p, input int k, input bit v, input bit e);
    port_valid    = NOISE_V;
    port_valid[p] = v;
    port_eop      = NOISE_E;
    port_eop[p]   = e;
    port_data[p*DW +: DW] = mk(p, k);
  endtask

  task automatic grant(input int p);
    arb_valid  = 1'b1;
    arb_select = 4'(p);
    port_req   = '0;
    port_req[p] = 1'b1;
    #1;
    chk("grant_ack", 64'(arb_ack), 64'd1);
    tick();
    arb_valid = 1'b0;
    port_req  = '0;
  endtask

  initial begin
    int xfers;
    int idx;
    int bad;
    rst        = 1'b1;
    arb_valid  = 1'b0;
    arb_select = '0;
    port_req   = '0;
    port_valid = NOISE_V;
    port_eop   = NOISE_E;
    wr_ready   = 1'b1;
    for (int i = 0; i < NP; i++) port_data[i*DW +: DW] = 32'hDEAD_0000 | 32'(i);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_wr_valid", 64'(wr_valid), 64'd0);
    chk("reset_port_ready", 64'(port_ready), 64'd0);
    chk("reset_outs", {wr_data, wr_port, wr_sop, wr_eop, err_abort, arb_ack}, 64'd0);

    // 4-beat packet on port 5
    grant(5);
    for (int k = 0; k < 4; k++) begin
      set_beat(5, k, 1'b1, k == 3);
      if (k == 1) begin
        arb_valid = 1'b1; arb_select = 4'd5; port_req = 16'h0020;
      end
      #1;
      chk("p5_valid", 64'(wr_valid), 64'd1);
      chk("p5_data", 64'(wr_data), 64'(mk(5, k)));
      chk("p5_sop", 64'(wr_sop), 64'(k == 0));
      chk("p5_eop", 64'(wr_eop), 64'(k == 3));
      chk("p5_port", 64'(wr_port), 64'd5);
      chk("p5_ready", 64'(port_ready), 64'h0020);
      chk("p5_no_ack", 64'(arb_ack), 64'd0);
      chk("p5_busy", 64'(busy), 64'd1);
      tick();
      arb_valid = 1'b0; port_req = '0;
    end
    set_beat(5, 4, 1'b0, 1'b0);
    #1;
    chk("p5_done_busy", 64'(busy), 64'd0);
    chk("p5_done_ready", 64'(port_ready), 64'd0);

    // Select of a port with no pending request is ignored
    arb_valid = 1'b1; arb_select = 4'd3; port_req = 16'hFFF7;
    #1;
    chk("noreq_ack", 64'(arb_ack), 64'd0);
    tick();
    arb_valid = 1'b0; port_req = '0;
    #1;
    chk("noreq_busy", 64'(busy), 64'd0);
    chk("noreq_ready", 64'(port_ready), 64'd0);

    // Port 2, 3 beats with wr_ready toggling
    grant(2);
    xfers = 0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      wr_ready = (c % 2 == 0);
      set_beat(2, idx, 1'b1, idx == 2);
      #1;
      chk("bp_data", 64'(wr_data), 64'(mk(2, idx)));
      chk("bp_ready", 64'(port_ready), wr_ready ? 64'h0004 : 64'h0);
      chk("bp_sop", 64'(wr_sop), 64'(idx == 0));
      chk("bp_err", 64'(err_abort), 64'd0);
      if (wr_valid && wr_ready) xfers++;
      if (wr_ready) idx++;
      tick();
    end
    wr_ready = 1'b1;
    set_beat(2, 3, 1'b0, 1'b0);
    #1;
    chk("bp_xfers", 64'(xfers), 64'd3);
    chk("bp_idle", {busy, err_abort}, 64'd0);

    // Port 7, MAX_WORDS+2 beats: forced eop on beat 63, then drain
    grant(7);
    for (int k = 0; k < 64; k++) begin
      set_beat(7, k, 1'b1, 1'b0);
      #1;
      chk("len_data", 64'(wr_data), 64'(mk(7, k)));
      chk("len_eop", 64'(wr_eop), 64'(k == 63));
      chk("len_err", 64'(err_abort), 64'd0);
      tick();
    end
    wr_ready = 1'b0;
    set_beat(7, 64, 1'b1, 1'b0);
    #1;
    chk("drain_err_pulse", 64'(err_abort), 64'd1);
    chk("drain_valid0", 64'(wr_valid), 64'd0);
    chk("drain_ready0", 64'(port_ready), 64'h0080);
    chk("drain_busy0", 64'(busy), 64'd1);
    tick();
    set_beat(7, 65, 1'b1, 1'b1);
    #1;
    chk("drain_err_once", 64'(err_abort), 64'd0);
    chk("drain_valid1", 64'(wr_valid), 64'd0);
    chk("drain_ready1", 64'(port_ready), 64'h0080);
    tick();
    wr_ready = 1'b1;
    set_beat(7, 66, 1'b0, 1'b0);
    #1;
    chk("drain_exit", 64'(busy), 64'd0);

    // Port 9: one beat then 255 idle cycles -> timeout
    grant(9);
    set_beat(9, 0, 1'b1, 1'b0);
    #1;
    chk("to_sop", 64'(wr_sop), 64'd1);
    tick();
    set_beat(9, 1, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      #1;
      if (err_abort || !busy || wr_eop) bad++;
      tick();
    end
    chk("to_quiet", 64'(bad), 64'd0);
    arb_valid = 1'b1; arb_select = 4'd1; port_req = 16'h0002;
    #1;
    chk("to_err", 64'(err_abort), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_eop", 64'(wr_eop), 64'd0);
    chk("to_regrant_ack", 64'(arb_ack), 64'd1);
    tick();
    arb_valid = 1'b0; port_req = '0;
    set_beat(1, 0, 1'b1, 1'b1);
    #1;
    chk("single_sop_eop", {wr_sop, wr_eop}, 64'd3);
    chk("single_port", 64'(wr_port), 64'd1);
    chk("single_err", 64'(err_abort), 64'd0);
    tick();
    set_beat(1, 1, 1'b0, 1'b0);
    #1;
    chk("single_done", 64'(busy), 64'd0);

    // Reset mid-packet on port 4
    grant(4);
    set_beat(4, 0, 1'b1, 1'b0);
    tick();
    set_beat(4, 1, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    set_beat(4, 2, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_outs", {wr_valid, wr_eop, wr_sop, err_abort, wr_port}, 64'd0);
    chk("rst_mid_ready", 64'(port_ready), 64'd0);
    grant(4);
    set_beat(4, 0, 1'b1, 1'b0);
    #1;
    chk("rst_regrant_sop", 64'(wr_sop), 64'd1);
    chk("rst_regrant_data", 64'(wr_data), 64'(mk(4, 0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
